// File: rtl/l2_mem_pkg.sv
// Shared types and widths for the L2 memory-side responder.
//   LINE_W  : cache line width in bits
//   ADDR_W  : line address width
//   state_t : responder FSM states
//   op_t    : captured request opcode
package l2_mem_pkg;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/l2_mem_responder_array.sv
// Single-port synchronous line storage.
//   clk, n_reset : clock, async active-high reset (read register only)
//   we, idx, wdata : line write at the rising edge
//   re, rdata      : registered line read; rdata holds between reads
module mem_line_array
  import l2_mem_pkg::*;
#(
  parameter int unsigned INDEX_W = 8
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               we,
  input  logic               re,
  input  logic [INDEX_W-1:0] idx,
  input  logic [LINE_W-1:0]  wdata,
  output logic [LINE_W-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << INDEX_W;

  logic [LINE_W-1:0] mem [DEPTH];

  // Storage itself is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register; only a completed read updates it.
  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/l2_mem_responder.sv
// Fixed-latency main-memory responder on the L2 memory-side port.
//   clk, n_reset         : clock, async active-high reset
//   mem_read, mem_write  : request levels, held until mem_ready
//   mem_addr, mem_wdata  : line address and write line
//   mem_ready            : one-cycle completion pulse
//   mem_rdata            : read line, valid in the ready cycle of a read
//   busy                 : a captured request is outstanding
module l2_mem_responder
  import l2_mem_pkg::*;
#(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned INDEX_W   = 8,
  parameter int unsigned INIT_ZERO = 0
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 8;

  // Time-0 clearing belongs to the sim build's memory wrapper; the array here has no power-up state.
  localparam bit unused_init_zero = (INIT_ZERO != 0);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  op_t                 op_q, op_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                arr_we, arr_re;
  logic                capture;
  logic                req;
  op_t                 req_op;

  // Upper address bits alias modulo the array depth.
  logic unused_addr;
  assign unused_addr = ^mem_addr[ADDR_W-1:INDEX_W];

  assign req    = mem_read | mem_write;
  assign req_op = mem_write ? OP_WRITE : OP_READ;

  // State and request registers.
  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      idx_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, capture and completion strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    arr_we  = 1'b0;
    arr_re  = 1'b0;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        capture = req;
      end
      BUSY: begin
        if (cnt_q == '0) begin
          arr_we  = (op_q == OP_WRITE);
          arr_re  = (op_q == OP_READ);
          ready_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // A request seen in the ready cycle is taken immediately (writeback-then-fill).
        if (req) begin
          capture = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      state_d = BUSY;
      cnt_d   = CNT_W'(LATENCY - 1);
      op_d    = req_op;
      idx_d   = mem_addr[INDEX_W-1:0];
      wdata_d = mem_wdata;
    end

    busy_d = (state_d != IDLE);
  end

  mem_line_array #(
    .INDEX_W (INDEX_W)
  ) u_array (
    .clk     (clk),
    .n_reset (n_reset),
    .we      (arr_we),
    .re      (arr_re),
    .idx     (idx_q),
    .wdata   (wdata_q),
    .rdata   (mem_rdata)
  );

  assign mem_ready = ready_q;
  assign busy      = busy_q;

  // Both request levels high is a protocol error; it is serviced as a write.
  a_rw_exclusive: assert property (@(posedge clk) disable iff (n_reset) !(mem_read && mem_write));

endmodule

// File: tb/tb_l2_mem_responder.sv
module tb_l2_mem_responder;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  typedef struct {
    int           cyc;
    logic [127:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         n_reset = 1'b1;
  logic         rd_s    [2];
  logic         wr_s    [2];
  logic [27:0]  addr_s  [2];
  logic [127:0] wdata_s [2];
  logic         ready_o [2];
  logic [127:0] rdata_o [2];
  logic         busy_o  [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t         q0 [$];
  exp_t         q1 [$];
  logic [127:0] mdl [int];
  logic [127:0] last_rd [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  l2_mem_responder #(.LATENCY(LAT0), .INDEX_W(8), .INIT_ZERO(0)) u_dut0 (
    .clk(clk), .n_reset(n_reset),
    .mem_read(rd_s[0]), .mem_write(wr_s[0]), .mem_addr(addr_s[0]), .mem_wdata(wdata_s[0]),
    .mem_ready(ready_o[0]), .mem_rdata(rdata_o[0]), .busy(busy_o[0])
  );

  l2_mem_responder #(.LATENCY(LAT1), .INDEX_W(8), .INIT_ZERO(0)) u_dut1 (
    .clk(clk), .n_reset(n_reset),
    .mem_read(rd_s[1]), .mem_write(wr_s[1]), .mem_addr(addr_s[1]), .mem_wdata(wdata_s[1]),
    .mem_ready(ready_o[1]), .mem_rdata(rdata_o[1]), .busy(busy_o[1])
  );

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Scoreboard monitors: pop an expectation on every ready pulse.
  always @(negedge clk) begin
    if (ready_o[0]) begin
      if (q0.size() == 0) begin
        chk("unexpected_ready0", 128'(q0.size()), 128'd1);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("ready_cycle0", 128'(cyc), 128'(e.cyc));
        chk("rdata0", rdata_o[0], e.data);
        chk("busy_at_ready0", 128'(busy_o[0]), 128'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (ready_o[1]) begin
      if (q1.size() == 0) begin
        chk("unexpected_ready1", 128'(q1.size()), 128'd1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("ready_cycle1", 128'(cyc), 128'(e.cyc));
        chk("rdata1", rdata_o[1], e.data);
        chk("busy_at_ready1", 128'(busy_o[1]), 128'd1);
      end
    end
  end

  // Called at a negedge just before the capture edge; computes the expectation from the bench model.
  task automatic push_exp(input int d, input bit is_wr, input logic [27:0] a, input logic [127:0] wd);
    exp_t e;
    int   k;
    k     = d * 256 + int'(a[7:0]);
    e.cyc = cyc + 1 + ((d == 0) ? LAT0 : LAT1);
    if (is_wr) begin
      e.data = last_rd[d];
      mdl[k] = wd;
    end else begin
      e.data     = mdl[k];
      last_rd[d] = mdl[k];
    end
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wait_ready(input int d);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (ready_o[d]) seen = 1'b1;
      else chk("busy_while_pending", 128'(busy_o[d]), 128'd1);
    end
    if (!seen) chk("ready_timeout", 128'(ready_o[d]), 128'd1);
  endtask

  // One request; keep=1 leaves the level asserted in the ready cycle.
  task automatic req(input int d, input bit is_wr, input logic [27:0] a,
                     input logic [127:0] wd, input bit keep);
    rd_s[d]    = !is_wr;
    wr_s[d]    = is_wr;
    addr_s[d]  = a;
    wdata_s[d] = wd;
    push_exp(d, is_wr, a, wd);
    wait_ready(d);
    if (!keep) begin
      rd_s[d] = 1'b0;
      wr_s[d] = 1'b0;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_s[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0; last_rd[d] = '0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", 128'(ready_o[d]), 128'd0);
      chk("reset_rdata", rdata_o[d], 128'd0);
      chk("reset_busy", 128'(busy_o[d]), 128'd0);
    end
    repeat (3) @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);

    // Preload then single read.
    req(0, 1'b1, 28'h0000005, {16{8'hA5}}, 1'b0);
    req(0, 1'b0, 28'h0000005, '0, 1'b0);
    @(negedge clk);
    // Write then read back.
    req(0, 1'b1, 28'h0000012, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
    req(0, 1'b0, 28'h0000012, '0, 1'b0);
    // Lines used by later tests.
    req(0, 1'b1, 28'h0000080, 128'hDEADBEEF_CAFEF00D_11223344_55667788, 1'b0);
    req(0, 1'b1, 28'h0000003, {16{8'h33}}, 1'b0);
    req(0, 1'b1, 28'h0000007, {16{8'h77}}, 1'b0);
    // Writeback-then-fill: switch to read in the ready cycle.
    req(0, 1'b1, 28'h0000040, 128'h40404040_0BADC0DE_40404040_FEEDFACE, 1'b1);
    req(0, 1'b0, 28'h0000080, '0, 1'b0);
    req(0, 1'b0, 28'h0000040, '0, 1'b0);

    // Inputs changed after capture are ignored.
    rd_s[0] = 1'b1; addr_s[0] = 28'h3;
    push_exp(0, 1'b0, 28'h3, '0);
    @(negedge clk);
    addr_s[0] = 28'h7; rd_s[0] = 1'b0;
    wait_ready(0);
    repeat (3) @(negedge clk);

    // Reset before the completion edge of a write.
    wr_s[0] = 1'b1; addr_s[0] = 28'h12; wdata_s[0] = {128{1'b1}};
    @(negedge clk);
    @(negedge clk);
    wr_s[0] = 1'b0;
    n_reset = 1'b1;
    #1;
    chk("midreset_ready", 128'(ready_o[0]), 128'd0);
    chk("midreset_rdata", rdata_o[0], 128'd0);
    chk("midreset_busy", 128'(busy_o[0]), 128'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    req(0, 1'b0, 28'h0000012, '0, 1'b0);

    // LATENCY=1 and address aliasing.
    req(1, 1'b1, 28'h0000005, 128'hCAFEBABE_00000005_CAFEBABE_00000005, 1'b0);
    req(1, 1'b0, 28'h0000105, '0, 1'b0);
    req(1, 1'b1, 28'h00001FF, 128'h1FF01FF0_1FF01FF0_1FF01FF0_1FF01FF0, 1'b0);
    req(1, 1'b0, 28'h00000FF, '0, 1'b0);

    repeat (10) @(negedge clk);
    chk("pending0_empty", 128'(q0.size()), 128'd0);
    chk("pending1_empty", 128'(q1.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_mem_responder.md
Name: l2_mem_responder

Overview:
- Main-memory responder on the L2 cache's memory-side port. It answers line-granular read and write requests after a fixed, parameterised latency.
- It sits below the L2 cache and holds a line array of 128-bit lines.
- It is used as the memory model in system sims and as the memory-controller front end in synthesis builds.

Parameters:
LATENCY, 4, cycles from request capture edge to the edge that raises mem_ready; legal range 1..255
INDEX_W, 8, line-array index width; depth = 2**INDEX_W lines, index = mem_addr[INDEX_W-1:0]
INIT_ZERO, 0, 1 = array cleared to zero in simulation at time 0 (not on reset)

Ports:
clk  input  1  clock, rising edge
n_reset  input  1  reset, asynchronous, active-high
mem_read  input  1  read request level, held by initiator until mem_ready
mem_write  input  1  write request level, held by initiator until mem_ready
mem_addr  input  28  line address
mem_wdata  input  128  write line data
mem_ready  output  1  one-cycle completion pulse, registered
mem_rdata  output  128  read line data, registered; valid in the mem_ready cycle of a read
busy  output  1  high while a captured request is outstanding (BUSY or RESP)

Behaviour:
- Reset (async, n_reset=1): state=IDLE, mem_ready=0, mem_rdata=0, busy=0, latency counter=0. Array contents are not reset.
- Reset mid-operation abandons the request. No array write is committed unless the completion edge has already occurred.
- States and transitions:
  - IDLE: when (mem_read|mem_write) is high at an edge, capture op, addr and wdata into the request registers, load counter=LATENCY-1, go to BUSY.
  - BUSY: the counter decrements each edge. At the edge where counter==0, complete the captured request, set mem_ready=1, go to RESP.
  - RESP: mem_ready is high for exactly this one cycle. At the next edge mem_ready=0. If (mem_read|mem_write) is high at that edge, capture the new request and go to BUSY (back-to-back). Otherwise go to IDLE.
- Completion edge:
  - Write: array[idx] <= captured wdata.
  - Read: mem_rdata <= array[idx], which reflects all earlier completed writes.
- mem_rdata holds its value until the next read completes; writes never change it.
- Latency: with LATENCY=L, mem_ready is high in the L-th cycle after the capture edge. With L=1, mem_ready is high in the cycle immediately after capture.
- Inputs are ignored while BUSY: changes to addr, wdata or op after capture have no effect, and dropping the request does not abort it.
- Inputs seen during the RESP cycle are treated as a new request. The initiator may switch write→read combinationally in the ready cycle (writeback-then-fill), and that read is captured at the edge ending RESP.
- mem_read and mem_write both high: treated as a write. A sim assertion flags it as a protocol error.
- Address bits above INDEX_W-1 are ignored, so addresses alias modulo the depth.
- No request can be lost: one outstanding at a time, and the initiator holds its request level until mem_ready.

Decomposition:
- Shared package l2_mem_pkg:
  - LINE_W=128, ADDR_W=28
  - state enum {IDLE, BUSY, RESP} as a 2-bit encoding
  - op encoding {OP_READ, OP_WRITE}
- Sub-module mem_line_array: single-port synchronous line storage with a parameter INDEX_W, inputs we/idx/wdata and registered rdata on re.
- The top level holds the FSM, latency counter and request registers.

Test Plan:
- Reset then single read: mem_read=1, addr=0x0000005 with array[5] preloaded to 128'hA5..A5, LATENCY=4 → mem_ready high exactly in the 4th cycle after capture, mem_rdata=A5..A5 in that cycle, busy=1 from capture through RESP.
- Write then read back: write addr=0x0000012, wdata=128'h0123...CDEF, then read the same addr → mem_rdata=0123...CDEF. Two ready pulses, each one cycle wide.
- Writeback-then-fill: write to addr 0x0000040 held until ready, with the initiator switching to read of addr 0x0000080 in the ready cycle → read captured at the edge ending RESP (no IDLE cycle) and ready again after LATENCY cycles.
- Inputs changed mid-BUSY: read captured with addr=0x3, then addr changed to 0x7 and mem_read dropped → completion still returns array[3], single ready pulse.
- Reset mid-write: write captured, n_reset pulsed before the completion edge → mem_ready=0 and mem_rdata=0 immediately; the array entry keeps its old value.
- LATENCY=1 and aliasing (INDEX_W=8): read addr=0x0000105 → ready in the cycle after capture and data=array[0x05].
